// File: rtl/reservoir_pkg.sv
// Shared types and default sizes for the reservoir scheduler.
package reservoir_pkg;

  localparam int RES_NUM_NEURONS = 16;
  localparam int RES_EXT_WIDTH   = 8;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_WAIT_IN,
    S_WRITE,
    S_SETTLE,
    S_CAPTURE,
    S_OUTPUT,
    S_DONE
  } res_sched_state_t;

endpackage

// File: rtl/reservoir_popcount.sv
// Combinational population count of a spike vector.
module reservoir_popcount #(
  parameter int WIDTH = 16,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic [WIDTH-1:0] vec,
  output logic [CNT_W-1:0] count
);

  always_comb begin
    count = '0;
    for (int i = 0; i < WIDTH; i++) begin
      count = count + CNT_W'(vec[i]);
    end
  end

endmodule

// File: rtl/reservoir_scheduler.sv
// Sequences one reservoir crossbar through a multi-timestep sample.
// Optional spike counting is enabled by defining RESERVOIR_SPIKE_COUNT_EN.
module reservoir_scheduler
  import reservoir_pkg::*;
#(
  parameter int NUM_NEURONS   = RES_NUM_NEURONS,
  parameter int EXT_WIDTH     = RES_EXT_WIDTH,
  parameter int SETTLE_CYCLES = 4,
  parameter int NUM_TIMESTEPS = 32,
  parameter int TS_W          = 8
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   start,
  input  logic                   abort,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [EXT_WIDTH-1:0]   in_data,
  output logic [EXT_WIDTH-1:0]   res_ein,
  output logic [NUM_NEURONS-1:0] res_spikes_in,
  output logic                   res_write,
  output logic                   res_clear,
  input  logic [NUM_NEURONS-1:0] res_spike_record,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [NUM_NEURONS-1:0] out_spikes,
  output logic [TS_W-1:0]        out_timestep,
  output logic                   out_last,
  output logic                   busy,
  output logic                   done
`ifdef RESERVOIR_SPIKE_COUNT_EN
  ,
  output logic [$clog2(NUM_NEURONS+1)-1:0] out_spike_count,
  output logic [15:0]                      sample_spike_total
`endif
);

  localparam logic [7:0]      SETTLE_LOAD = 8'(SETTLE_CYCLES - 1);
  localparam logic [TS_W-1:0] TS_LAST     = TS_W'(NUM_TIMESTEPS - 1);

  res_sched_state_t state_q, state_d;
  logic [7:0]       settle_cnt;
  logic [TS_W-1:0]  ts;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:    if (start) state_d = S_CLEAR;
      S_CLEAR:   state_d = S_WAIT_IN;
      S_WAIT_IN: if (in_valid) state_d = S_WRITE;
      S_WRITE:   state_d = S_SETTLE;
      S_SETTLE:  if (settle_cnt == '0) state_d = S_CAPTURE;
      S_CAPTURE: state_d = S_OUTPUT;
      S_OUTPUT:  if (out_ready) state_d = out_last ? S_DONE : S_WAIT_IN;
      S_DONE:    state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
    if (abort) state_d = S_IDLE;
  end

  // Control strobes come straight off the state register.
  assign in_ready  = (state_q == S_WAIT_IN);
  assign res_write = (state_q == S_WRITE);
  assign res_clear = (state_q == S_CLEAR);
  assign out_valid = (state_q == S_OUTPUT);
  assign busy      = (state_q != S_IDLE);
  assign done      = (state_q == S_DONE);

  // Abort freezes the datapath so held crossbar inputs survive until the next CLEAR.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      res_ein       <= '0;
      res_spikes_in <= '0;
      out_spikes    <= '0;
      out_timestep  <= '0;
      out_last      <= 1'b0;
      settle_cnt    <= '0;
      ts            <= '0;
    end else if (!abort) begin
      case (state_q)
        S_CLEAR: begin
          res_spikes_in <= '0;
          ts            <= '0;
        end
        S_WAIT_IN: if (in_valid) res_ein <= in_data;
        S_WRITE:   settle_cnt <= SETTLE_LOAD;
        S_SETTLE:  if (settle_cnt != '0) settle_cnt <= settle_cnt - 8'd1;
        S_CAPTURE: begin
          res_spikes_in <= res_spike_record;
          out_spikes    <= res_spike_record;
          out_timestep  <= ts;
          out_last      <= (ts == TS_LAST);
        end
        S_OUTPUT:  if (out_ready && !out_last) ts <= ts + TS_W'(1);
        default: ;
      endcase
    end
  end

`ifdef RESERVOIR_SPIKE_COUNT_EN
  localparam int CNT_W = $clog2(NUM_NEURONS + 1);

  logic [CNT_W-1:0] record_count;

  function automatic logic [15:0] sat_add16(input logic [15:0] acc, input logic [CNT_W-1:0] inc);
    logic [16:0] sum;
    sum = {1'b0, acc} + 17'(inc);
    return sum[16] ? 16'hFFFF : sum[15:0];
  endfunction

  reservoir_popcount #(
    .WIDTH (NUM_NEURONS),
    .CNT_W (CNT_W)
  ) u_popcount (
    .vec   (res_spike_record),
    .count (record_count)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      out_spike_count    <= '0;
      sample_spike_total <= '0;
    end else if (!abort) begin
      if (state_q == S_CLEAR) begin
        sample_spike_total <= '0;
      end else if (state_q == S_CAPTURE) begin
        out_spike_count    <= record_count;
        sample_spike_total <= sat_add16(sample_spike_total, record_count);
      end
    end
  end
`endif

endmodule

// File: tb/tb_reservoir_scheduler.sv
// Directed, table-driven bench for reservoir_scheduler (4 timesteps per sample).
module tb_reservoir_scheduler;

  localparam int NN = 16;
  localparam int EW = 8;
  localparam int SC = 4;
  localparam int NT = 4;
  localparam int TW = 8;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic          in_valid = 1'b0;
  logic [EW-1:0] in_data = '0;
  logic          out_ready = 1'b1;
  logic          in_ready;
  logic [EW-1:0] res_ein;
  logic [NN-1:0] res_spikes_in;
  logic          res_write;
  logic          res_clear;
  logic [NN-1:0] res_spike_record;
  logic          out_valid;
  logic [NN-1:0] out_spikes;
  logic [TW-1:0] out_timestep;
  logic          out_last;
  logic          busy;
  logic          done;
`ifdef RESERVOIR_SPIKE_COUNT_EN
  logic [4:0]    out_spike_count;
  logic [15:0]   sample_spike_total;
`endif

  always #5 clock = ~clock;

  // Crossbar stand-in: Ein of all ones yields 16'hBDF6, anything else a simple mix.
  assign res_spike_record = (res_ein == 8'hFF) ? 16'hBDF6 : {res_ein ^ 8'h5A, res_ein};

  reservoir_scheduler #(
    .NUM_NEURONS   (NN),
    .EXT_WIDTH     (EW),
    .SETTLE_CYCLES (SC),
    .NUM_TIMESTEPS (NT),
    .TS_W          (TW)
  ) dut (
    .clock            (clock),
    .reset            (reset),
    .start            (start),
    .abort            (abort),
    .in_valid         (in_valid),
    .in_ready         (in_ready),
    .in_data          (in_data),
    .res_ein          (res_ein),
    .res_spikes_in    (res_spikes_in),
    .res_write        (res_write),
    .res_clear        (res_clear),
    .res_spike_record (res_spike_record),
    .out_valid        (out_valid),
    .out_ready        (out_ready),
    .out_spikes       (out_spikes),
    .out_timestep     (out_timestep),
    .out_last         (out_last),
    .busy             (busy),
    .done             (done)
`ifdef RESERVOIR_SPIKE_COUNT_EN
    ,
    .out_spike_count    (out_spike_count),
    .sample_spike_total (sample_spike_total)
`endif
  );

  typedef struct {
    logic [7:0]  din;
    logic [15:0] spk_in;
    logic [15:0] spk_out;
    logic [7:0]  ts;
    logic        last;
    int          cnt;
  } vec_t;

  vec_t tbl[8];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_in_ready"}, in_ready, 0);
    chk({tag, "_res_ein"}, res_ein, 0);
    chk({tag, "_res_spikes_in"}, res_spikes_in, 0);
    chk({tag, "_res_write"}, res_write, 0);
    chk({tag, "_res_clear"}, res_clear, 0);
    chk({tag, "_out_valid"}, out_valid, 0);
    chk({tag, "_out_spikes"}, out_spikes, 0);
    chk({tag, "_out_timestep"}, out_timestep, 0);
    chk({tag, "_out_last"}, out_last, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
  endtask

  // Runs one sample from table rows base..base+NT-1. stall_ts holds out_ready low
  // for 10 cycles on that timestep; stray_k pulses start at that cycle of the run.
  task automatic run_sample(input int base, input int stall_ts, input int stray_k, output int span);
    int          idx, nout, wi, k, stall_left, clears, total;
    logic [15:0] snap;
    logic        acc_in, acc_out;
    bit          got_done;
    idx = 0; nout = 0; wi = 0; clears = 0; stall_left = 10; got_done = 0; total = 0; snap = '0;
    for (int i = 0; i < NT; i++) total += tbl[base + i].cnt;
    start = 1'b1;
    step();
    start = 1'b0;
    k = 1;
    for (int guard = 0; guard < 600; guard++) begin
      if (res_clear) clears++;
      if (res_write) begin
        if (wi < NT) begin
          chk("write_ein", res_ein, tbl[base + wi].din);
          chk("write_spikes_in", res_spikes_in, tbl[base + wi].spk_in);
        end
        wi++;
      end
      if (done) begin
        got_done = 1;
        break;
      end
      start     = (k == stray_k);
      in_valid  = in_ready && (idx < NT);
      in_data   = (idx < NT) ? tbl[base + idx].din : '0;
      out_ready = 1'b1;
      if (out_valid && nout == stall_ts && stall_left > 0) begin
        if (stall_left == 10) snap = out_spikes;
        else begin
          chk("stall_out_valid", out_valid, 1);
          chk("stall_out_spikes", out_spikes, snap);
        end
        chk("stall_no_in_ready", in_ready, 0);
        out_ready = 1'b0;
        stall_left--;
      end
      acc_in  = in_valid && in_ready;
      acc_out = out_valid && out_ready;
      if (acc_out && nout < NT) begin
        chk("out_spikes", out_spikes, tbl[base + nout].spk_out);
        chk("out_timestep", out_timestep, tbl[base + nout].ts);
        chk("out_last", out_last, tbl[base + nout].last);
`ifdef RESERVOIR_SPIKE_COUNT_EN
        chk("out_spike_count", out_spike_count, tbl[base + nout].cnt);
`endif
      end
      step();
      k++;
      if (acc_in) idx++;
      if (acc_out) nout++;
    end
    start    = 1'b0;
    in_valid = 1'b0;
    chk("done_seen", got_done, 1);
    chk("write_count", wi, NT);
    chk("output_count", nout, NT);
    chk("clear_count", clears, 1);
`ifdef RESERVOIR_SPIKE_COUNT_EN
    chk("sample_spike_total", sample_spike_total, total);
`endif
    span = k + 1;
    step();
    chk("done_one_cycle", done, 0);
    chk("idle_after_done", busy, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    int span, writes;
    tbl[0] = '{8'hFF, 16'h0000, 16'hBDF6, 8'd0, 1'b0, 12};
    tbl[1] = '{8'hFF, 16'hBDF6, 16'hBDF6, 8'd1, 1'b0, 12};
    tbl[2] = '{8'hFF, 16'hBDF6, 16'hBDF6, 8'd2, 1'b0, 12};
    tbl[3] = '{8'hFF, 16'hBDF6, 16'hBDF6, 8'd3, 1'b1, 12};
    tbl[4] = '{8'h12, 16'h0000, 16'h4812, 8'd0, 1'b0, 4};
    tbl[5] = '{8'h00, 16'h4812, 16'h5A00, 8'd1, 1'b0, 4};
    tbl[6] = '{8'hFF, 16'h5A00, 16'hBDF6, 8'd2, 1'b0, 12};
    tbl[7] = '{8'h81, 16'hBDF6, 16'hDB81, 8'd3, 1'b1, 8};

    // Power-on reset.
    repeat (2) @(posedge clock);
    #1;
    check_zero("por");
`ifdef RESERVOIR_SPIKE_COUNT_EN
    chk("por_spike_total", sample_spike_total, 0);
`endif
    reset = 1'b1;
    step();
    chk("post_reset_busy", busy, 0);

    // Stall-free sample: start cycle through done cycle inclusive is 2 + NT*(SC+4) + 1.
    run_sample(0, -1, -1, span);
    chk("done_latency", span, 2 + NT * (SC + 4) + 1);
    step();

    // Asynchronous reset in the middle of SETTLE of timestep 0.
    start = 1'b1;
    step();
    start = 1'b0;
    for (int g = 0; g < 20 && !res_write; g++) begin
      in_valid = in_ready;
      in_data  = 8'hFF;
      step();
    end
    in_valid = 1'b0;
    chk("reached_write", res_write, 1);
    step();
    step();
    chk("mid_settle_busy", busy, 1);
    #2 reset = 1'b0;
    #1 check_zero("async_reset");
    @(posedge clock);
    #1 check_zero("held_reset");
    #2 reset = 1'b1;
    for (int c = 0; c < 4; c++) begin
      step();
      chk("post_release_busy", busy, 0);
      chk("post_release_write", res_write, 0);
    end

    // Varied inputs with backpressure on timestep 1 and a start issued while busy.
    run_sample(4, 1, 20, span);
    for (int c = 0; c < 3; c++) begin
      step();
      chk("stray_start_not_queued", busy, 0);
    end

    // Abort during SETTLE of timestep 2.
    start = 1'b1;
    step();
    start = 1'b0;
    writes = 0;
    for (int g = 0; g < 100; g++) begin
      if (res_write) writes++;
      if (writes == 3) break;
      in_valid  = in_ready;
      in_data   = 8'hFF;
      out_ready = 1'b1;
      step();
    end
    in_valid = 1'b0;
    chk("abort_reached_ts2_write", writes, 3);
    step();
    chk("abort_pre_busy", busy, 1);
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_out_valid", out_valid, 0);
    chk("abort_keeps_ein", res_ein, 8'hFF);
    chk("abort_keeps_spikes_in", res_spikes_in, 16'hBDF6);
    for (int c = 0; c < 3; c++) begin
      step();
      chk("abort_no_done", done, 0);
    end

    // Restart after abort begins again from timestep 0 with a clear.
    run_sample(0, -1, -1, span);
    chk("rerun_latency", span, 2 + NT * (SC + 4) + 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
